seg_scan_decoder: RTL and testbench

Receive-side counterpart of the hex-to-seven-segment encoder.
- Samples a time-multiplexed, active-low 7-segment display bus: one-hot-low digit select plus 8 segment lines.
- Debounces each digit dwell and decodes the segment pattern back to a 4-bit hex value.
- Assembles a per-digit value register and pulses when a full frame (every digit) has been captured.
- Used as a display-bus monitor/loopback checker beside the display driver.

---
 rtl/seg_scan_decoder_pkg.sv | 28 ++
 rtl/seg_scan_decoder_decode.sv | 20 ++
 rtl/seg_scan_decoder.sv | 173 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants and types for seven-segment bus decoding (active-low, bit7=a .. bit1=g, bit0=dp).
package seg_pkg;

  localparam int SEG_A_BIT  = 7;
  localparam int SEG_G_BIT  = 1;
  localparam int SEG_DP_BIT = 0;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // a-g codes indexed by hex value, dp excluded
  localparam logic [15:0][6:0] SEG_CODES = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] nibble;
  } seg_dec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } seg_state_e;

endpackage

// File: rtl/seg_scan_decoder_decode.sv
// Combinational a-g pattern to hex decode; reports blank or legal nibble, neither flag means undecodable.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern_i,
  output seg_dec_t   result_o
);

  always_comb begin
    result_o = '0;
    if (pattern_i == SEG_BLANK) result_o.blank = 1'b1;
    for (int v = 0; v < 16; v++) begin
      if (pattern_i == SEG_CODES[v]) begin
        result_o.valid  = 1'b1;
        result_o.nibble = 4'(v);
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Multiplexed 7-seg bus monitor: debounces each digit dwell, decodes it, flags complete frames.
// Commit lands STABLE_CYCLES+1 edges after the input settles; SEG_DP_CAPTURE_EN adds the dp_out port.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  input  logic [7:0]              seg_in,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    frame_done,
  output logic                    err
`ifdef SEG_DP_CAPTURE_EN
  ,
  output logic [NUM_DIGITS-1:0]   dp_out
`endif
);

  localparam int SW = NUM_DIGITS + 8;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  seg_state_e                  state_q, state_d;
  logic [SW-1:0]               s_q, s_prev_q;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]       mask_q, mask_d;
  logic [NUM_DIGITS-1:0][3:0]  value_q, value_d;
  logic [NUM_DIGITS-1:0]       valid_q, valid_d;
  logic [NUM_DIGITS-1:0]       blank_q, blank_d;
  logic                        err_q, err_d;
  logic                        frame_q, frame_d;
`ifdef SEG_DP_CAPTURE_EN
  logic [NUM_DIGITS-1:0]       dp_q, dp_d;
`endif

  logic [NUM_DIGITS-1:0] smp_sel;
  logic [7:0]            smp_seg;
  logic                  legal, changed, commit;
  logic [IW-1:0]         idx;
  seg_dec_t              dec;

  assign smp_sel = s_q[SW-1:8];
  assign smp_seg = s_q[7:0];
  assign legal   = ($countones(~smp_sel) == 1);
  assign changed = (s_q != s_prev_q);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!smp_sel[i]) idx = IW'(i);
    end
  end

  seg_pattern_decode u_decode (
    .pattern_i (smp_seg[SEG_A_BIT:SEG_G_BIT]),
    .result_o  (dec)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    value_d = value_q;
    valid_d = valid_q;
    blank_d = blank_q;
    err_d   = 1'b0;
    frame_d = 1'b0;
    commit  = 1'b0;
`ifdef SEG_DP_CAPTURE_EN
    dp_d    = dp_q;
`endif

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      mask_d  = '0;
    end else begin
      // An illegal select behaves like a change that can never mature
      if (!legal)                                 cnt_d = '0;
      else if (changed)                           cnt_d = CW'(1);
      else if (cnt_q != CW'(STABLE_CYCLES))       cnt_d = cnt_q + CW'(1);

      case (state_q)
        ST_IDLE: begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
        ST_SETTLE: begin
          if (legal && !changed && cnt_q == CW'(STABLE_CYCLES)) begin
            commit  = 1'b1;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!legal || changed) state_d = ST_SETTLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (commit) begin
      if (dec.valid) begin
        value_d[idx] = dec.nibble;
        valid_d[idx] = 1'b1;
        blank_d[idx] = 1'b0;
      end else if (dec.blank) begin
        value_d[idx] = 4'h0;
        valid_d[idx] = 1'b0;
        blank_d[idx] = 1'b1;
      end else begin
        valid_d[idx] = 1'b0;
        blank_d[idx] = 1'b0;
        err_d        = 1'b1;
      end
`ifdef SEG_DP_CAPTURE_EN
      dp_d[idx] = ~smp_seg[SEG_DP_BIT];
`endif
      mask_d[idx] = 1'b1;
      if (&mask_d) begin
        frame_d = 1'b1;
        mask_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      s_prev_q <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      value_q  <= '0;
      valid_q  <= '0;
      blank_q  <= '1;
      err_q    <= 1'b0;
      frame_q  <= 1'b0;
`ifdef SEG_DP_CAPTURE_EN
      dp_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      s_q      <= {digit_sel, seg_in};
      s_prev_q <= s_q;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
      frame_q  <= frame_d;
`ifdef SEG_DP_CAPTURE_EN
      dp_q     <= dp_d;
`endif
    end
  end

  assign value_out   = value_q;
  assign digit_valid = valid_q;
  assign blank       = blank_q;
  assign err         = err_q;
  assign frame_done  = frame_q;
`ifdef SEG_DP_CAPTURE_EN
  assign dp_out      = dp_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios plus random dwells against a run-length reference model.
module tb_seg_scan_decoder;

  localparam int ND = 8;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [7:0]  digit_sel = 8'hFF;
  logic [7:0]  seg_in = 8'hFF;
  logic [31:0] value_out;
  logic [7:0]  digit_valid;
  logic [7:0]  blank;
  logic        frame_done;
  logic        err;
`ifdef SEG_DP_CAPTURE_EN
  logic [7:0]  dp_out;
`endif

  always #5 clk = ~clk;

  seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .digit_sel   (digit_sel),
    .seg_in      (seg_in),
    .value_out   (value_out),
    .digit_valid (digit_valid),
    .blank       (blank),
    .frame_done  (frame_done),
    .err         (err)
`ifdef SEG_DP_CAPTURE_EN
    ,
    .dp_out      (dp_out)
`endif
  );

  // Display codes with dp off, indexed by hex value
  logic [7:0] code8 [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                             8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  int checks = 0;
  int errors = 0;
  int n_frame = 0;
  int n_err = 0;

  logic [31:0] m_value = '0;
  logic [7:0]  m_valid = '0;
  logic [7:0]  m_blank = '1;
  logic [7:0]  m_mask = '0;
  logic [7:0]  m_dp = '0;
  logic        m_err = 1'b0;
  logic        m_frame = 1'b0;
  logic [15:0] run_val = '0;
  int          run_len = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply the effect of a dwell of identical samples that has just matured
  task automatic model_commit(input logic [15:0] smp);
    int zeros = 0;
    int slot = 0;
    int v = -1;
    for (int i = 0; i < 8; i++) begin
      if (!smp[8+i]) begin
        zeros++;
        slot = i;
      end
    end
    if (zeros != 1) return;
    for (int k = 0; k < 16; k++) begin
      if ((smp[7:0] | 8'h01) == code8[k]) v = k;
    end
    if (v >= 0) begin
      m_value[4*slot +: 4] = 4'(v);
      m_valid[slot] = 1'b1;
      m_blank[slot] = 1'b0;
    end else if ((smp[7:0] | 8'h01) == 8'hFF) begin
      m_value[4*slot +: 4] = 4'h0;
      m_valid[slot] = 1'b0;
      m_blank[slot] = 1'b1;
    end else begin
      m_valid[slot] = 1'b0;
      m_blank[slot] = 1'b0;
      m_err = 1'b1;
    end
    m_dp[slot] = ~smp[0];
    m_mask[slot] = 1'b1;
    if (m_mask == 8'hFF) begin
      m_frame = 1'b1;
      m_mask = '0;
    end
  endtask

  // A run of identical samples commits once, on the edge after its (SC+1)th sample
  task automatic model_edge(input logic r, input logic e, input logic [15:0] smp);
    m_err = 1'b0;
    m_frame = 1'b0;
    if (r) begin
      m_value = '0;
      m_valid = '0;
      m_blank = '1;
      m_mask = '0;
      m_dp = '0;
      run_len = 0;
    end else if (!e) begin
      m_mask = '0;
      run_len = 0;
    end else begin
      if (run_len == SC + 1) model_commit(run_val);
      if (run_len > 0 && smp == run_val) begin
        if (run_len < 1000) run_len++;
      end else begin
        run_val = smp;
        run_len = 1;
      end
    end
  endtask

  task automatic step(input logic e, input logic [7:0] sel, input logic [7:0] sg, input logic r);
    en = e;
    digit_sel = sel;
    seg_in = sg;
    rst = r;
    @(posedge clk);
    model_edge(r, e, {sel, sg});
    @(negedge clk);
    check("value", value_out, m_value);
    check("valid", digit_valid, m_valid);
    check("blank", blank, m_blank);
    check("frame", frame_done, m_frame);
    check("err", err, m_err);
`ifdef SEG_DP_CAPTURE_EN
    check("dp", dp_out, m_dp);
`endif
    if (frame_done) n_frame++;
    if (err) n_err++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int nf0;
    int ne0;
    int len;
    int g;
    logic e;
    logic [7:0] sel;
    logic [7:0] pat;

    @(negedge clk);
    step(1'b0, 8'hFF, 8'hFF, 1'b1);
    check("rst_value", value_out, 32'h0);
    check("rst_valid", digit_valid, 8'h00);
    check("rst_blank", blank, 8'hFF);
    check("rst_frame", frame_done, 1'b0);
    check("rst_err", err, 1'b0);
    repeat (3) step(1'b1, 8'hFF, 8'hFF, 1'b0);

    // Single digit, latency boundary
    repeat (5) step(1'b1, 8'hFE, 8'h25, 1'b0);
    check("t1_early", digit_valid[0], 1'b0);
    step(1'b1, 8'hFE, 8'h25, 1'b0);
    check("t1_val", value_out[3:0], 4'h2);
    check("t1_valid", digit_valid[0], 1'b1);
    check("t1_blank", blank[0], 1'b0);

    // Bouncing pattern never settles
    ne0 = n_err;
    repeat (4) begin
      repeat (2) step(1'b1, 8'hFE, 8'h0D, 1'b0);
      repeat (2) step(1'b1, 8'hFE, 8'h25, 1'b0);
    end
    check("t2_hold", value_out[3:0], 4'h2);
    check("t2_noerr", n_err - ne0, 0);

    // Full scan of digits 0..7
    step(1'b1, 8'hFF, 8'hFF, 1'b1);
    repeat (2) step(1'b1, 8'hFF, 8'hFF, 1'b0);
    nf0 = n_frame;
    for (int d = 0; d < 8; d++) begin
      sel = 8'hFF;
      sel[d] = 1'b0;
      repeat (6) step(1'b1, sel, code8[d], 1'b0);
    end
    check("t3_value", value_out, 32'h76543210);
    check("t3_valid", digit_valid, 8'hFF);
    check("t3_frames", n_frame - nf0, 1);

    // Blank, dp-only change, then an undecodable pattern
    repeat (6) step(1'b1, 8'hF7, 8'hFF, 1'b0);
    check("t4_blank", blank[3], 1'b1);
    repeat (6) step(1'b1, 8'hF7, 8'hFE, 1'b0);
    check("t4_blank_dp", blank[3], 1'b1);
    ne0 = n_err;
    repeat (6) step(1'b1, 8'hF7, 8'hAA, 1'b0);
    check("t4_err", n_err - ne0, 1);
    check("t4_valid", digit_valid[3], 1'b0);
    check("t4_blank_clr", blank[3], 1'b0);

    // Two selects low, then reset mid-dwell
    ne0 = n_err;
    repeat (10) step(1'b1, 8'hFC, 8'h25, 1'b0);
    check("t5_noerr", n_err - ne0, 0);
    repeat (3) step(1'b1, 8'hFE, 8'h0D, 1'b0);
    step(1'b1, 8'hFE, 8'h0D, 1'b1);
    check("t5_rst_value", value_out, 32'h0);
    check("t5_rst_valid", digit_valid, 8'h00);
    check("t5_rst_blank", blank, 8'hFF);

`ifdef SEG_DP_CAPTURE_EN
    repeat (6) step(1'b1, 8'hDF, 8'h48, 1'b0);
    check("t6_val", value_out[23:20], 4'h5);
    check("t6_dp", dp_out[5], 1'b1);
`endif

    // Random dwells, glitches, illegal selects and enable drops
    pat = 8'hFF;
    repeat (400) begin
      sel = 8'hFF;
      sel[$urandom_range(0, 7)] = 1'b0;
      if ($urandom_range(0, 9) == 0) sel = 8'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: pat = code8[$urandom_range(0, 15)] & {7'h7F, 1'($urandom)};
        7:                   pat = {7'h7F, 1'($urandom)};
        8:                   pat = 8'($urandom);
        default:             pat = pat ^ 8'h01;
      endcase
      e = ($urandom_range(0, 29) != 0);
      len = $urandom_range(1, 10);
      g = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
      for (int c = 0; c < len; c++) step(e, sel, (c == g) ? (pat ^ 8'h10) : pat, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
